// File: rtl/sobel_frame_ctrl_if.sv
// Signal bundle between the Sobel frame controller, its pixel source, the gradient
// datapath and the edge-map writer. The master modport is the controller's view.
interface sobel_frame_ctrl_if #(
  parameter int nbit = 8
);
  logic            start;
  logic [nbit-1:0] thresh;
  logic [nbit-1:0] in_pixel;
  logic            in_valid;
  logic            in_ready;
  logic [nbit-1:0] win_p0, win_p1, win_p2;
  logic [nbit-1:0] win_p3, win_p4, win_p5;
  logic [nbit-1:0] win_p6, win_p7, win_p8;
  logic [nbit-1:0] win_t;
  logic [nbit-1:0] grad_in;
  logic            dop_in;
  logic [nbit-1:0] out_grad;
  logic            out_edge;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  modport master (
    input  start, thresh, in_pixel, in_valid, grad_in, dop_in, out_ready,
    output in_ready, win_p0, win_p1, win_p2, win_p3, win_p4, win_p5,
           win_p6, win_p7, win_p8, win_t, out_grad, out_edge, out_valid, busy, done
  );

  modport slave (
    output start, thresh, in_pixel, in_valid, grad_in, dop_in, out_ready,
    input  in_ready, win_p0, win_p1, win_p2, win_p3, win_p4, win_p5,
           win_p6, win_p7, win_p8, win_t, out_grad, out_edge, out_valid, busy, done
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame controller for a 3x3 Sobel datapath: two line buffers feed a sliding window,
// the returned magnitude/edge flag is registered with valid/ready back-pressure.
module sobel_frame_ctrl #(
  parameter int nbit  = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic               clk,
  input logic               rst,
  sobel_frame_ctrl_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [nbit-1:0] r_thresh;
  logic [nbit-1:0] r_lb1 [IMG_W];
  logic [nbit-1:0] r_lb2 [IMG_W];
  logic [nbit-1:0] r_win [9];
  logic            r_vld_p1;
  logic            r_vld_p2;
  logic [nbit-1:0] r_grad_p2;
  logic            r_edge_p2;

  logic w_stall, w_in_ready, w_accept, w_busy, w_done;
  logic w_col_last, w_row_last, w_interior;

  assign w_stall    = r_vld_p2 & ~bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_row_last && w_col_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_vld_p1 && !r_vld_p2) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_in_ready = (r_state == S_RUN) & ~w_stall;
    w_busy     = (r_state == S_RUN) | (r_state == S_DRAIN);
    w_done     = (r_state == S_DONE);
  end

  // Raster position and threshold; row wraps on the last pixel so it never reaches IMG_H
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row    <= '0;
      r_col    <= '0;
      r_thresh <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_row    <= '0;
      r_col    <= '0;
      r_thresh <= bus.thresh;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers hold only pixel data, so they carry no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= bus.in_pixel;
    end
  end

  // Stage p1: window shift and interior-centre flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= r_lb2[r_col];
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= r_lb1[r_col];
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= bus.in_pixel;
      r_vld_p1 <= w_interior;
    end else if (!w_stall) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Stage p2: registered datapath result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_grad_p2 <= '0;
      r_edge_p2 <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p2  <= r_vld_p1;
      r_grad_p2 <= bus.grad_in;
      r_edge_p2 <= bus.dop_in;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.win_p0    = r_win[0];
  assign bus.win_p1    = r_win[1];
  assign bus.win_p2    = r_win[2];
  assign bus.win_p3    = r_win[3];
  assign bus.win_p4    = r_win[4];
  assign bus.win_p5    = r_win[5];
  assign bus.win_p6    = r_win[6];
  assign bus.win_p7    = r_win[7];
  assign bus.win_p8    = r_win[8];
  assign bus.win_t     = r_thresh;
  assign bus.out_grad  = r_grad_p2;
  assign bus.out_edge  = r_edge_p2;
  assign bus.out_valid = r_vld_p2;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: a 4x4 and a 5x4 instance share stimulus,
// a behavioural Sobel unit closes the datapath loop, expectations come from the image.
module tb_sobel_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] thresh = '0;
  logic [7:0] pix = '0;
  logic       vld = 1'b0;
  logic       ordy = 1'b1;
  int         rmode = 0;
  bit         sel = 1'b0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_out = 0, n_done = 0, hs_cyc = 0, done_cyc = 0, win_due = -5;
  int img [0:63];
  int q_g[$];
  int q_e[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_frame_ctrl_if #(.nbit(8)) if44 ();
  sobel_frame_ctrl_if #(.nbit(8)) if54 ();

  sobel_frame_ctrl #(.nbit(8), .IMG_W(4), .IMG_H(4)) u_d44 (.clk(clk), .rst(rst), .bus(if44));
  sobel_frame_ctrl #(.nbit(8), .IMG_W(5), .IMG_H(4)) u_d54 (.clk(clk), .rst(rst), .bus(if54));

  function automatic int sobel_mag(input int a, input int b, input int c, input int d,
                                   input int f, input int g, input int h, input int i);
    int gx, gy, m;
    gx = (c + 2*f + i) - (a + 2*d + g);
    gy = (g + 2*h + i) - (a + 2*b + c);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  int g44, g54;
  assign g44 = sobel_mag(int'(if44.win_p0), int'(if44.win_p1), int'(if44.win_p2), int'(if44.win_p3),
                         int'(if44.win_p5), int'(if44.win_p6), int'(if44.win_p7), int'(if44.win_p8));
  assign g54 = sobel_mag(int'(if54.win_p0), int'(if54.win_p1), int'(if54.win_p2), int'(if54.win_p3),
                         int'(if54.win_p5), int'(if54.win_p6), int'(if54.win_p7), int'(if54.win_p8));
  assign if44.grad_in = g44[7:0];
  assign if44.dop_in  = (g44 > int'(if44.win_t));
  assign if54.grad_in = g54[7:0];
  assign if54.dop_in  = (g54 > int'(if54.win_t));

  assign if44.start = start;   assign if54.start = start;
  assign if44.thresh = thresh; assign if54.thresh = thresh;
  assign if44.in_pixel = pix;  assign if54.in_pixel = pix;
  assign if44.in_valid = vld;  assign if54.in_valid = vld;
  assign if44.out_ready = ordy; assign if54.out_ready = ordy;

  logic       s_in_ready, s_out_valid, s_out_edge, s_busy, s_done;
  logic [7:0] s_out_grad;
  always_comb begin
    if (sel) begin
      s_in_ready = if54.in_ready; s_out_valid = if54.out_valid; s_out_edge = if54.out_edge;
      s_busy = if54.busy; s_done = if54.done; s_out_grad = if54.out_grad;
    end else begin
      s_in_ready = if44.in_ready; s_out_valid = if44.out_valid; s_out_edge = if44.out_edge;
      s_busy = if44.busy; s_done = if44.done; s_out_grad = if44.out_grad;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       ordy = 1'b1;
      1:       ordy = ~ordy;
      default: ordy = 1'b0;
    endcase
  end

  int eg, ee;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_out_valid && ordy) begin
        chk("sb_nonempty", int'(q_g.size() > 0), 1);
        if (q_g.size() > 0) begin
          eg = q_g.pop_front();
          ee = q_e.pop_front();
          chk("out_grad", s_out_grad, eg);
          chk("out_edge", s_out_edge, ee);
        end
        n_out++;
        hs_cyc = cyc;
      end
      if (s_out_valid && !ordy) chk("in_ready_stall", s_in_ready, 0);
      if (s_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (win_due == cyc) begin
        chk("win_p0", if44.win_p0, img[0]);  chk("win_p1", if44.win_p1, img[1]);
        chk("win_p2", if44.win_p2, img[2]);  chk("win_p3", if44.win_p3, img[4]);
        chk("win_p4", if44.win_p4, img[5]);  chk("win_p5", if44.win_p5, img[6]);
        chk("win_p6", if44.win_p6, img[8]);  chk("win_p7", if44.win_p7, img[9]);
        chk("win_p8", if44.win_p8, img[10]);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; vld = 1'b0; rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q_g.delete(); q_e.delete();
    win_due = -5;
  endtask

  task automatic run_frame(input int w, input int h, input int kind, input int th, input int rm,
                           input int abort_at, input bit t5, input bit hold_last, input bit win_chk);
    int n, idx, acc, guard, r, c, m, out0, done0;
    n = w * h;
    for (int k = 0; k < n; k++) begin
      case (kind)
        0:       img[k] = 100;
        1:       img[k] = k;
        default: img[k] = int'($urandom_range(0, 255));
      endcase
    end
    sel = (w == 5);
    do_reset();
    rmode = rm;
    out0 = n_out; done0 = n_done;
    start = 1'b1; thresh = th[7:0];
    @(posedge clk); #1;
    start = 1'b0; vld = 1'b1; pix = img[0][7:0];
    idx = 0; acc = 0; guard = 0;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (s_in_ready) begin
        r = idx / w; c = idx % w;
        if (r >= 2 && c >= 2) begin
          m = sobel_mag(img[(r-2)*w+c-2], img[(r-2)*w+c-1], img[(r-2)*w+c],
                        img[(r-1)*w+c-2], img[(r-1)*w+c],
                        img[r*w+c-2], img[r*w+c-1], img[r*w+c]);
          q_g.push_back(m);
          q_e.push_back(int'(m > th));
        end
        if (win_chk && idx == 2*w + 2) win_due = cyc + 1;
        idx++; acc++;
      end
      @(posedge clk); #1;
      if (t5) begin
        start = (idx == 5);
        if (idx == 5) thresh = 8'd10;
      end
      if (abort_at > 0 && acc == abort_at) break;
      if (idx < n) pix = img[idx][7:0];
      else vld = 1'b0;
      if (hold_last && idx == n - 1) rmode = 2;
    end
    start = 1'b0;
    chk("frame_accept_bound", int'(guard < 1000), 1);
    if (abort_at > 0) begin
      rst = 1'b1; vld = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", s_busy, 0);       chk("abort_in_ready", s_in_ready, 0);
      chk("abort_out_valid", s_out_valid, 0); chk("abort_out_grad", s_out_grad, 0);
      chk("abort_out_edge", s_out_edge, 0);   chk("abort_win_p4", if44.win_p4, 0);
      chk("abort_win_t", if44.win_t, 0);
      rst = 1'b0;
      q_g.delete(); q_e.delete();
      @(negedge clk);
      chk("abort_no_done", n_done - done0, 0);
      return;
    end
    if (hold_last) begin
      repeat (5) @(negedge clk);
      chk("hold_busy", s_busy, 1);
      chk("hold_out_valid", s_out_valid, 1);
      chk("hold_no_done", n_done - done0, 0);
      @(posedge clk); #1;
      rmode = 0;
    end
    guard = 0;
    while (!s_done && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk); #1;
    chk("done_seen", n_done - done0, 1);
    chk("done_latency", int'(done_cyc - hs_cyc >= 1 && done_cyc - hs_cyc <= 2), 1);
    @(posedge clk); #1;
    chk("idle_after_done", s_busy, 0);
    chk("done_one_cycle", s_done, 0);
    chk("out_count", n_out - out0, (w-2)*(h-2));
    chk("sb_drained", q_g.size(), 0);
    chk("accepts", acc, n);
  endtask

  initial begin
    do_reset();
    chk("rst_in_ready", s_in_ready, 0); chk("rst_out_valid", s_out_valid, 0);
    chk("rst_busy", s_busy, 0);         chk("rst_done", s_done, 0);
    chk("rst_out_grad", s_out_grad, 0); chk("rst_out_edge", s_out_edge, 0);
    chk("rst_win_p0", if44.win_p0, 0);  chk("rst_win_p8", if44.win_p8, 0);
    chk("rst_win_t", if44.win_t, 0);

    run_frame(4, 4, 0, 1,   0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, 1, 0,   0, 0, 1'b0, 1'b0, 1'b1);
    run_frame(5, 4, 2, 100, 1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, 2, 60,  0, 7, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, 2, 60,  0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, 1, 50,  0, 0, 1'b1, 1'b0, 1'b0);
    run_frame(4, 4, 1, 20,  0, 0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
